// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and sizing for the cacheline adaptor: the burst FSM states
// and the default line/beat geometry.
package cacheline_adaptor_pkg;

    localparam int BURST_W_DEF = 64;
    localparam int BEATS_DEF   = 4;
    localparam int LINE_W_DEF  = BURST_W_DEF * BEATS_DEF;
    localparam int ADDR_W_DEF  = 32;

    // Byte offset bits within one 32-byte cacheline.
    localparam int LINE_OFFSET = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Converts one 256-bit cacheline read/write from the cache controller into a
// 4-beat 64-bit burst on physical memory, then pulses resp_o for one cycle.
module cacheline_adaptor
    import cacheline_adaptor_pkg::*;
#(
    parameter int BURST_W = BURST_W_DEF,
    parameter int BEATS   = BEATS_DEF,
    parameter int LINE_W  = BURST_W * BEATS,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LINE_W-1:0] line_i,
    output logic [LINE_W-1:0] line_o,
    input  logic [ADDR_W-1:0] address_i,
    input  logic              read_i,
    input  logic              write_i,
    output logic              resp_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [ADDR_W-1:0] address_o,
    output logic              read_o,
    output logic              write_o,
    input  logic              resp_i
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    // Clears the in-line byte offset so memory always sees an aligned address.
    localparam logic [ADDR_W-1:0] ADDR_MASK =
        {{(ADDR_W - LINE_OFFSET){1'b1}}, {LINE_OFFSET{1'b0}}};

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [ADDR_W-1:0]  addr_q;
    logic [LINE_W-1:0]  line_q;
    logic               last_beat;

    assign last_beat = (cnt == LAST_BEAT);
    assign address_o = addr_q;
    // Write beats are selected straight from the latched line by the counter.
    assign burst_o   = line_q[int'(cnt) * BURST_W +: BURST_W];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and Moore request/response outputs.
    always_comb begin
        state_nxt = state;
        read_o    = 1'b0;
        write_o   = 1'b0;
        resp_o    = 1'b0;
        case (state)
            IDLE: begin
                if (write_i) begin
                    state_nxt = WRITE;
                end else if (read_i) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                read_o = 1'b1;
                if (resp_i && last_beat) begin
                    state_nxt = DONE;
                end
            end
            WRITE: begin
                write_o = 1'b1;
                if (resp_i && last_beat) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                resp_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request latching, beat counting and read-line assembly. The counter
    // parks on the last beat rather than wrapping; IDLE clears it on start.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            addr_q <= '0;
            line_q <= '0;
            line_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (write_i) begin
                        addr_q <= address_i & ADDR_MASK;
                        line_q <= line_i;
                        cnt    <= '0;
                    end else if (read_i) begin
                        addr_q <= address_i & ADDR_MASK;
                        cnt    <= '0;
                    end
                end
                READ: begin
                    if (resp_i) begin
                        line_o[int'(cnt) * BURST_W +: BURST_W] <= burst_i;
                        if (!last_beat) begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                WRITE: begin
                    if (resp_i && !last_beat) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: read, gapped read, write, write-back
// followed by fill, mid-burst reset, request priority and idle resp_i.
module tb_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int compared   = 0;
    int mismatched = 0;

    localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;
    localparam logic [63:0] B5 = 64'h5555_5555_5555_5555;
    localparam logic [63:0] B6 = 64'h6666_6666_6666_6666;
    localparam logic [63:0] B7 = 64'h7777_7777_7777_7777;
    localparam logic [63:0] B8 = 64'h8888_8888_8888_8888;
    localparam logic [63:0] WA = 64'hAAAA_AAAA_0000_000A;
    localparam logic [63:0] WB = 64'hBBBB_BBBB_0000_000B;
    localparam logic [63:0] WC = 64'hCCCC_CCCC_0000_000C;
    localparam logic [63:0] WD = 64'hDDDD_DDDD_0000_000D;
    localparam logic [63:0] JUNK = 64'hDEAD_BEEF_DEAD_BEEF;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [63:0]  wbeats [4];
    logic [63:0]  rbeats [4];
    logic         gap_pat [7];
    logic [255:0] line1;
    logic [255:0] line2;
    logic [255:0] wline;
    int           k;

    initial begin
        wbeats = '{WA, WB, WC, WD};
        rbeats = '{B1, B2, B3, B4};
        gap_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        line1 = {B4, B3, B2, B1};
        line2 = {B8, B7, B6, B5};
        wline = {WD, WC, WB, WA};

        rst = 1'b1; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
        burst_i = '0; resp_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_resp_o", 256'(resp_o), 256'(1'b0));
        chk("rst_read_o", 256'(read_o), 256'(1'b0));
        chk("rst_write_o", 256'(write_o), 256'(1'b0));
        chk("rst_line_o", line_o, 256'h0);
        chk("rst_address_o", 256'(address_o), 256'h0);
        chk("rst_burst_o", 256'(burst_o), 256'h0);

        // Read, four back-to-back beats
        address_i = 32'h0000_1234; read_i = 1'b1;
        tick();
        read_i = 1'b0; address_i = 32'hFFFF_FFFF;
        chk("rd_read_o", 256'(read_o), 256'(1'b1));
        chk("rd_address_o", 256'(address_o), 256'h0000_1220);
        for (int i = 0; i < 4; i++) begin
            resp_i = 1'b1; burst_i = rbeats[i];
            tick();
        end
        resp_i = 1'b0; burst_i = JUNK;
        chk("rd_done_resp_o", 256'(resp_o), 256'(1'b1));
        chk("rd_done_read_o", 256'(read_o), 256'(1'b0));
        chk("rd_line_o", line_o, line1);
        tick();
        chk("rd_idle_resp_o", 256'(resp_o), 256'(1'b0));
        chk("rd_idle_line_hold", line_o, line1);

        // Read with gaps in resp_i
        address_i = 32'h0000_2000; read_i = 1'b1;
        tick();
        read_i = 1'b0;
        k = 0;
        for (int i = 0; i < 7; i++) begin
            chk("gap_read_o", 256'(read_o), 256'(1'b1));
            chk("gap_resp_o", 256'(resp_o), 256'(1'b0));
            resp_i = gap_pat[i];
            burst_i = gap_pat[i] ? rbeats[k] : JUNK;
            if (gap_pat[i]) k++;
            tick();
        end
        resp_i = 1'b0;
        chk("gap_done_resp_o", 256'(resp_o), 256'(1'b1));
        chk("gap_done_read_o", 256'(read_o), 256'(1'b0));
        chk("gap_line_o", line_o, line1);
        tick();

        // Write, beats advance only on resp_i
        address_i = 32'h0000_ABCF; line_i = wline; write_i = 1'b1;
        tick();
        write_i = 1'b0; line_i = {4{JUNK}}; address_i = 32'h0;
        chk("wr_write_o", 256'(write_o), 256'(1'b1));
        chk("wr_address_o", 256'(address_o), 256'h0000_ABC0);
        chk("wr_beat0", 256'(burst_o), 256'(WA));
        tick();
        chk("wr_beat0_hold", 256'(burst_o), 256'(WA));
        for (int i = 0; i < 4; i++) begin
            chk("wr_burst_o", 256'(burst_o), 256'(wbeats[i]));
            chk("wr_write_o_hi", 256'(write_o), 256'(1'b1));
            resp_i = 1'b1;
            tick();
            resp_i = 1'b0;
        end
        chk("wr_done_write_o", 256'(write_o), 256'(1'b0));
        chk("wr_done_resp_o", 256'(resp_o), 256'(1'b1));
        tick();
        chk("wr_idle_resp_o", 256'(resp_o), 256'(1'b0));

        // Write-back followed immediately by fill
        address_i = 32'h0000_4040; line_i = wline; write_i = 1'b1;
        tick();
        chk("wbf_write_o", 256'(write_o), 256'(1'b1));
        resp_i = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        resp_i = 1'b0;
        chk("wbf_done_resp_o", 256'(resp_o), 256'(1'b1));
        tick();
        write_i = 1'b0; read_i = 1'b1; address_i = 32'h0000_8061;
        chk("wbf_idle_write_o", 256'(write_o), 256'(1'b0));
        chk("wbf_idle_read_o", 256'(read_o), 256'(1'b0));
        chk("wbf_idle_resp_o", 256'(resp_o), 256'(1'b0));
        tick();
        read_i = 1'b0;
        chk("wbf_fill_read_o", 256'(read_o), 256'(1'b1));
        chk("wbf_fill_address_o", 256'(address_o), 256'h0000_8060);
        resp_i = 1'b1; burst_i = B5; tick();
        burst_i = B6; tick();
        burst_i = B7; tick();
        burst_i = B8; tick();
        resp_i = 1'b0;
        chk("wbf_fill_resp_o", 256'(resp_o), 256'(1'b1));
        chk("wbf_fill_line_o", line_o, line2);
        tick();

        // Reset after two read beats
        address_i = 32'h0000_3000; read_i = 1'b1;
        tick();
        read_i = 1'b0;
        resp_i = 1'b1; burst_i = B1; tick();
        burst_i = B2; tick();
        resp_i = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_read_o", 256'(read_o), 256'(1'b0));
        chk("mid_rst_resp_o", 256'(resp_o), 256'(1'b0));
        chk("mid_rst_line_o", line_o, 256'h0);
        chk("mid_rst_address_o", 256'(address_o), 256'h0);
        chk("mid_rst_burst_o", 256'(burst_o), 256'h0);
        tick();
        chk("mid_rst_idle_read_o", 256'(read_o), 256'(1'b0));
        address_i = 32'h0000_3000; read_i = 1'b1;
        tick();
        read_i = 1'b0;
        chk("post_rst_read_o", 256'(read_o), 256'(1'b1));
        for (int i = 0; i < 4; i++) begin
            resp_i = 1'b1; burst_i = rbeats[i];
            tick();
        end
        resp_i = 1'b0;
        chk("post_rst_resp_o", 256'(resp_o), 256'(1'b1));
        chk("post_rst_line_o", line_o, line1);
        tick();

        // Both requests high: write wins
        address_i = 32'h0000_5000; line_i = wline; read_i = 1'b1; write_i = 1'b1;
        tick();
        read_i = 1'b0; write_i = 1'b0;
        chk("prio_write_o", 256'(write_o), 256'(1'b1));
        chk("prio_read_o", 256'(read_o), 256'(1'b0));
        resp_i = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        resp_i = 1'b0;
        chk("prio_done_resp_o", 256'(resp_o), 256'(1'b1));
        tick();

        // resp_i in IDLE changes nothing
        resp_i = 1'b1; burst_i = JUNK;
        tick();
        tick();
        tick();
        resp_i = 1'b0;
        chk("idle_resp_read_o", 256'(read_o), 256'(1'b0));
        chk("idle_resp_write_o", 256'(write_o), 256'(1'b0));
        chk("idle_resp_resp_o", 256'(resp_o), 256'(1'b0));
        chk("idle_resp_line_o", line_o, line1);
        chk("idle_resp_burst_o", 256'(burst_o), 256'(WD));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
